// File: rtl/priority_encoder_if.sv
// Request/result bundle for priority_encoder: request vector with valid strobe in,
// registered index with valid flag out.
interface priority_encoder_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a;
    logic             vin;
    logic [IdxW-1:0]  out;
    logic             vout;

    modport master (
        output a,
        output vin,
        input  out,
        input  vout
    );

    modport slave (
        input  a,
        input  vin,
        output out,
        output vout
    );
endinterface

// File: rtl/priority_encoder.sv
// Registered MSB-first priority encoder: one-cycle latency, one result per cycle,
// output valid only for a qualified, non-zero request vector.
module priority_encoder #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    priority_encoder_if.slave bus
);
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IdxW-1:0] enc_idx;
    logic            any_req;
    logic [IdxW-1:0] out_d, out_q;
    logic            vout_d, vout_q;

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        enc_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.a[i]) begin
                enc_idx = IdxW'(i);
            end
        end
    end

    assign any_req = |bus.a;

    // Gating on vin keeps an undriven request vector from reaching the register.
    always_comb begin
        out_d  = '0;
        vout_d = 1'b0;
        if (bus.vin && any_req) begin
            out_d  = enc_idx;
            vout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            vout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            vout_q <= vout_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.vout = vout_q;
endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed vector table, a reset-in-stream
// sequence and randomised traffic, all checked through an expected-result queue.
module tb_priority_encoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    priority_encoder_if #(.WIDTH(8)) bus ();

    priority_encoder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] a;
        logic [2:0] out;
        logic       vout;
        string      name;
    } vec_t;

    typedef struct {
        logic [2:0] out;
        logic       vout;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t model(input logic r, input logic v, input logic [7:0] a,
                                   input string name);
        exp_t e;
        logic found;
        e.out  = 3'd0;
        e.vout = 1'b0;
        e.name = name;
        found  = 1'b0;
        if (!r && v) begin
            for (int i = 7; i >= 0; i--) begin
                if (!found && a[i]) begin
                    e.out  = 3'(i);
                    e.vout = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic void add(input logic r, input logic v, input logic [7:0] a,
                                input logic [2:0] o, input logic vo, input string name);
        vec_t t;
        t.rst  = r;
        t.vin  = v;
        t.a    = a;
        t.out  = o;
        t.vout = vo;
        t.name = name;
        vecs.push_back(t);
    endfunction

    task automatic check_out();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: out=%0d vout=%0d with no expected entry",
                     bus.out, bus.vout);
        end else begin
            e = sb.pop_front();
            if (bus.out !== e.out || bus.vout !== e.vout) begin
                n_fail++;
                $display("FAIL %s: got out=%0d vout=%0d, expected out=%0d vout=%0d",
                         e.name, bus.out, bus.vout, e.out, e.vout);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input logic r, input logic v, input logic [7:0] a, input exp_t e);
        rst     = r;
        bus.vin = v;
        bus.a   = a;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic r, v;
        logic [7:0] a;

        // Reset held with a live request must keep the outputs clear.
        add(1, 1, 8'hFF, 3'd0, 0, "reset_hold0");
        add(1, 1, 8'hFF, 3'd0, 0, "reset_hold1");
        add(0, 1, 8'h80, 3'd7, 1, "first_after_reset");
        for (int i = 0; i < 8; i++) begin
            add(0, 1, 8'(1 << i), 3'(i), 1, $sformatf("walk_%0d", i));
        end
        add(0, 1, 8'hFF, 3'd7, 1, "mask_FF");
        add(0, 1, 8'h3C, 3'd5, 1, "mask_3C");
        add(0, 1, 8'h11, 3'd4, 1, "mask_11");
        add(0, 1, 8'h03, 3'd1, 1, "mask_03");
        add(0, 1, 8'h00, 3'd0, 0, "zero_req");
        add(0, 0, 8'hA5, 3'd0, 0, "vin_low");
        add(0, 1, 8'h40, 3'd6, 1, "toggle_1");
        add(0, 0, 8'h40, 3'd0, 0, "toggle_0");
        add(0, 1, 8'h40, 3'd6, 1, "toggle_1b");
        add(0, 0, 8'hxx, 3'd0, 0, "x_when_idle");

        rst     = 1'b1;
        bus.vin = 1'b0;
        bus.a   = 8'h00;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            e.out  = vecs[k].out;
            e.vout = vecs[k].vout;
            e.name = vecs[k].name;
            apply(vecs[k].rst, vecs[k].vin, vecs[k].a, e);
        end

        // Reset in the middle of back-to-back traffic drops that cycle's capture only.
        apply(0, 1, 8'h20, model(0, 1, 8'h20, "seq_pre"));
        apply(1, 1, 8'hFF, model(1, 1, 8'hFF, "seq_mid_rst"));
        apply(0, 1, 8'h04, model(0, 1, 8'h04, "seq_post"));
        apply(0, 1, 8'h01, model(0, 1, 8'h01, "seq_bit0"));

        for (int n = 0; n < 1000; n++) begin
            r = ($urandom_range(0, 39) == 0);
            v = 1'($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'(1 << $urandom_range(0, 7));
            apply(r, v, a, model(r, v, a, $sformatf("rand_%0d", n)));
        end

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
